// File: rtl/spatz_vsldu_wbuf.sv
// Write-back staging FIFO between the VSLDU VRF write interface and the VRF write port.
// Optional tail-merge of same-address writes when SPATZ_VSLDU_WBUF_MERGE_EN is defined.
module spatz_vsldu_wbuf #(
  parameter int unsigned NrEntries  = 2,
  parameter int unsigned AddrWidth  = 10,
  parameter int unsigned DataWidth  = 64,
  localparam int unsigned BeWidth    = DataWidth / 8,
  localparam int unsigned UsageWidth = $clog2(NrEntries) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  sld_waddr_i,
  input  logic [DataWidth-1:0]  sld_wdata_i,
  input  logic [BeWidth-1:0]    sld_wbe_i,
  input  logic                  sld_we_i,
  output logic                  sld_wvalid_o,
  output logic [AddrWidth-1:0]  vrf_waddr_o,
  output logic [DataWidth-1:0]  vrf_wdata_o,
  output logic [BeWidth-1:0]    vrf_wbe_o,
  output logic                  vrf_we_o,
  input  logic                  vrf_wvalid_i,
  input  logic [AddrWidth-1:0]  lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);

  localparam int unsigned PtrW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
  localparam logic [UsageWidth-1:0] Full = UsageWidth'(NrEntries);
  localparam logic [PtrW-1:0]       LastIdx = PtrW'(NrEntries - 1);

  logic [AddrWidth-1:0]  addr_q [NrEntries];
  logic [AddrWidth-1:0]  addr_d [NrEntries];
  logic [DataWidth-1:0]  data_q [NrEntries];
  logic [DataWidth-1:0]  data_d [NrEntries];
  logic [BeWidth-1:0]    be_q   [NrEntries];
  logic [BeWidth-1:0]    be_d   [NrEntries];
  logic [NrEntries-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;

  logic pop, alloc, merge;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign vrf_we_o    = (usage_q != '0);
  assign vrf_waddr_o = addr_q[rptr_q];
  assign vrf_wdata_o = data_q[rptr_q];
  assign vrf_wbe_o   = be_q[rptr_q];
  assign empty_o     = (usage_q == '0);
  assign usage_o     = usage_q;

  assign pop = vrf_we_o & vrf_wvalid_i;

`ifdef SPATZ_VSLDU_WBUF_MERGE_EN
  logic [PtrW-1:0] tail_ptr;
  assign tail_ptr = (wptr_q == '0) ? LastIdx : wptr_q - 1'b1;
  // A lone entry being committed this cycle cannot absorb the write.
  assign merge = sld_we_i && (usage_q != '0) && (addr_q[tail_ptr] == sld_waddr_i)
                 && !(pop && (usage_q == UsageWidth'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc        = sld_we_i & ~merge & ((usage_q < Full) | pop);
  assign sld_wvalid_o = alloc | merge;

  always_comb begin
    lookup_hit_o = 1'b0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr_i)) lookup_hit_o = 1'b1;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    valid_d = valid_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    usage_d = usage_q;

    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = ptr_inc(rptr_q);
    end

    // Allocation is applied after the pop so a 1-deep full queue can refill the same slot.
    if (alloc) begin
      addr_d[wptr_q]  = sld_waddr_i;
      data_d[wptr_q]  = sld_wdata_i;
      be_d[wptr_q]    = sld_wbe_i;
      valid_d[wptr_q] = 1'b1;
      wptr_d          = ptr_inc(wptr_q);
    end

`ifdef SPATZ_VSLDU_WBUF_MERGE_EN
    if (merge) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (sld_wbe_i[b]) data_d[tail_ptr][8*b +: 8] = sld_wdata_i[8*b +: 8];
      end
      be_d[tail_ptr] = be_q[tail_ptr] | sld_wbe_i;
    end
`endif

    case ({alloc, pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NrEntries; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      valid_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      usage_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      usage_q <= usage_d;
    end
  end

endmodule

// File: tb/tb_spatz_vsldu_wbuf.sv
// Self-checking bench for spatz_vsldu_wbuf: directed scenarios plus random traffic
// compared against a queue-based reference model of the staging buffer.
module tb_spatz_vsldu_wbuf;

  localparam int unsigned N = 2;

  logic        clk;
  logic        rst_ni;
  logic [9:0]  sld_waddr;
  logic [63:0] sld_wdata;
  logic [7:0]  sld_wbe;
  logic        sld_we;
  logic        sld_wvalid;
  logic [9:0]  vrf_waddr;
  logic [63:0] vrf_wdata;
  logic [7:0]  vrf_wbe;
  logic        vrf_we;
  logic        vrf_wvalid;
  logic [9:0]  lookup_addr;
  logic        lookup_hit;
  logic        empty;
  logic [1:0]  usage;

  spatz_vsldu_wbuf #(.NrEntries(N), .AddrWidth(10), .DataWidth(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .sld_waddr_i  (sld_waddr),
    .sld_wdata_i  (sld_wdata),
    .sld_wbe_i    (sld_wbe),
    .sld_we_i     (sld_we),
    .sld_wvalid_o (sld_wvalid),
    .vrf_waddr_o  (vrf_waddr),
    .vrf_wdata_o  (vrf_wdata),
    .vrf_wbe_o    (vrf_wbe),
    .vrf_we_o     (vrf_we),
    .vrf_wvalid_i (vrf_wvalid),
    .lookup_addr_i(lookup_addr),
    .lookup_hit_o (lookup_hit),
    .empty_o      (empty),
    .usage_o      (usage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  a;
    logic [63:0] d;
    logic [7:0]  be;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge_data(input logic [63:0] old_d, input logic [63:0] new_d,
                                             input logic [7:0] be);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, clock, update model.
  task automatic step(input logic we, input logic [9:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic wv, input logic [9:0] la);
    logic e_pop, e_merge, e_alloc, e_hit;
    int   sz;
    sld_we = we; sld_waddr = a; sld_wdata = d; sld_wbe = be;
    vrf_wvalid = wv; lookup_addr = la;
    #1;
    sz      = q.size();
    e_pop   = (sz != 0) && wv;
    e_merge = 1'b0;
`ifdef SPATZ_VSLDU_WBUF_MERGE_EN
    e_merge = we && (sz != 0) && (q[sz-1].a == a) && !(e_pop && sz == 1);
`endif
    e_alloc = we && !e_merge && ((sz < N) || e_pop);
    e_hit   = 1'b0;
    foreach (q[i]) if (q[i].a == la) e_hit = 1'b1;
    check("wvalid", 64'(sld_wvalid), 64'(e_alloc || e_merge));
    check("vrf_we", 64'(vrf_we), 64'(sz != 0));
    check("usage", 64'(usage), 64'(sz));
    check("empty", 64'(empty), 64'(sz == 0));
    check("lookup", 64'(lookup_hit), 64'(e_hit));
    if (sz != 0) begin
      check("head_addr", 64'(vrf_waddr), 64'(q[0].a));
      check("head_data", vrf_wdata, q[0].d);
      check("head_be", 64'(vrf_wbe), 64'(q[0].be));
    end
    @(posedge clk);
    if (e_merge) begin
      q[sz-1].d  = merge_data(q[sz-1].d, d, be);
      q[sz-1].be = q[sz-1].be | be;
    end
    if (e_pop) void'(q.pop_front());
    if (e_alloc) q.push_back('{a: a, d: d, be: be});
    #1;
  endtask

  task automatic idle(input logic wv);
    step(1'b0, 10'd0, 64'd0, 8'd0, wv, 10'd0);
  endtask

  task automatic do_reset();
    sld_we = 1'b0; vrf_wvalid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    q.delete();
    check("rst_vrf_we", 64'(vrf_we), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_usage", 64'(usage), 64'd0);
    check("rst_sld_wvalid", 64'(sld_wvalid), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b1; sld_we = 1'b0; sld_waddr = '0; sld_wdata = '0; sld_wbe = '0;
    vrf_wvalid = 1'b0; lookup_addr = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("por_vrf_we", 64'(vrf_we), 64'd0);
    check("por_head_addr", 64'(vrf_waddr), 64'd0);
    check("por_head_data", vrf_wdata, 64'd0);
    check("por_head_be", 64'(vrf_wbe), 64'd0);
    check("por_lookup", 64'(lookup_hit), 64'd0);
    check("por_empty", 64'(empty), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Basic pass-through with the VRF always granting.
    step(1'b1, 10'd5, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 1'b1, 10'd5);
    check("pt_usage_after_push", 64'(usage), 64'd1);
    check("pt_head_addr", 64'(vrf_waddr), 64'd5);
    idle(1'b1);
    check("pt_drained", 64'(usage), 64'd0);
    idle(1'b1);

    // Fill and backpressure.
    step(1'b1, 10'd1, 64'h1111, 8'hFF, 1'b0, 10'd0);
    step(1'b1, 10'd2, 64'h2222, 8'hFF, 1'b0, 10'd0);
    step(1'b1, 10'd3, 64'h3333, 8'hFF, 1'b0, 10'd0);
    check("full_usage", 64'(usage), 64'd2);
    // Full with pop: the write to 3 is taken while address 1 commits.
    step(1'b1, 10'd3, 64'h3333, 8'hFF, 1'b1, 10'd3);
    check("fullpop_usage", 64'(usage), 64'd2);
    check("fullpop_head", 64'(vrf_waddr), 64'd2);
    idle(1'b1);
    check("fullpop_head3", 64'(vrf_waddr), 64'd3);
    idle(1'b1);
    idle(1'b1);

    // Lookup while 7 and 9 are pending, then after 9 leaves.
    step(1'b1, 10'd7, 64'h7777, 8'hFF, 1'b0, 10'd9);
    step(1'b1, 10'd9, 64'h9999, 8'h00, 1'b0, 10'd9);
    step(1'b0, 10'd0, 64'd0, 8'd0, 1'b0, 10'd9);
    check("lookup_hit9", 64'(lookup_hit), 64'd1);
    step(1'b0, 10'd0, 64'd0, 8'd0, 1'b1, 10'd4);
    step(1'b0, 10'd0, 64'd0, 8'd0, 1'b1, 10'd9);
    step(1'b0, 10'd0, 64'd0, 8'd0, 1'b0, 10'd9);
    check("lookup_after_pop", 64'(lookup_hit), 64'd0);

    // Reset mid-stream with two writes pending.
    step(1'b1, 10'd11, 64'hBEEF, 8'hFF, 1'b0, 10'd0);
    step(1'b1, 10'd12, 64'hCAFE, 8'hFF, 1'b0, 10'd0);
    check("pre_rst_usage", 64'(usage), 64'd2);
    do_reset();
    idle(1'b1);
    idle(1'b1);

    // Two partial writes to one address.
    step(1'b1, 10'd4, 64'h1111_1111_1111_1111, 8'h0F, 1'b0, 10'd4);
    step(1'b1, 10'd4, 64'h2222_2222_2222_2222, 8'hF0, 1'b0, 10'd4);
    idle(1'b0);
`ifdef SPATZ_VSLDU_WBUF_MERGE_EN
    check("merge_usage", 64'(usage), 64'd1);
    check("merge_be", 64'(vrf_wbe), 64'hFF);
    check("merge_data", vrf_wdata, 64'h2222_2222_1111_1111);
`else
    check("nomerge_usage", 64'(usage), 64'd2);
    check("nomerge_be", 64'(vrf_wbe), 64'h0F);
`endif
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic over a small address range to stress lookup and ordering.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rbe;
      rbe = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 3) != 0), 10'($urandom_range(0, 5)),
           {$urandom, $urandom}, rbe, ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
           10'($urandom_range(0, 5)));
      if (i == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spatz_vsldu_wbuf.md
Name: spatz_vsldu_wbuf

Overview:
- Write-back staging buffer between the VSLDU VRF write interface (upstream) and the VRF write port (downstream).
- Accepts VSLDU writes in the same cycle and holds them in a small in-order queue while the VRF port is granted to another unit. This lets the slide unit keep its read/write lockstep without stalling on each write grant.
- Provides a pending-address lookup so the read side can detect data still in flight to the VRF.

Parameters:
- NrEntries, 2, queue depth in entries; must be a power of two, minimum 1.
- Entry payload: address is vreg_addr_t, data is vreg_data_t, byte enable is vreg_be_t (spatz_pkg types).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- sld_waddr_i  in  $bits(vreg_addr_t)  VSLDU write address
- sld_wdata_i  in  $bits(vreg_data_t)  VSLDU write data
- sld_wbe_i  in  $bits(vreg_be_t)  VSLDU byte enables
- sld_we_i  in  1  VSLDU write request
- sld_wvalid_o  out  1  write accepted this cycle (the VSLDU's vrf_wvalid_i)
- vrf_waddr_o  out  $bits(vreg_addr_t)  head entry address
- vrf_wdata_o  out  $bits(vreg_data_t)  head entry data
- vrf_wbe_o  out  $bits(vreg_be_t)  head entry byte enables
- vrf_we_o  out  1  head entry valid / write request
- vrf_wvalid_i  in  1  VRF committed the head write this cycle
- lookup_addr_i  in  $bits(vreg_addr_t)  address to check for pending writes
- lookup_hit_o  out  1  some valid entry matches lookup_addr_i
- empty_o  out  1  no entries held
- usage_o  out  $clog2(NrEntries)+1  number of valid entries

Behaviour:
- Storage and pointers:
  - Circular queue with read pointer, write pointer and usage counter, each $clog2(NrEntries) bits plus a usage MSB.
  - Pointers wrap modulo NrEntries.
- Reset values (asynchronous, active-low):
  - All entries invalid, pointers 0, usage 0.
  - vrf_we_o=0, vrf_waddr_o/vrf_wdata_o/vrf_wbe_o=0, sld_wvalid_o=0, lookup_hit_o=0, empty_o=1.
  - Reset mid-operation discards pending writes; the owner resets the VSLDU together with this block.
- Push:
  - pop = vrf_we_o & vrf_wvalid_i.
  - sld_wvalid_o = sld_we_i & (usage<NrEntries | pop). Combinational, same cycle as the request.
  - On acceptance the entry is written at the write pointer on the next edge and the write pointer advances.
  - A push when full is allowed only if a pop occurs in the same cycle.
- Pop:
  - vrf_* outputs are driven from the head entry; vrf_we_o = (usage!=0). Minimum input-to-VRF latency is 1 cycle (no combinational bypass).
  - On pop the read pointer advances. Head outputs must stay stable while vrf_we_o=1 and vrf_wvalid_i=0.
- Usage counter:
  - usage_d = usage + push - pop.
  - Simultaneous push and pop leaves usage unchanged.
  - Push into empty with no pop gives usage 1.
- Byte enables:
  - An entry with sld_wbe_i=0 is still queued and written (the VRF ignores it); the block never drops it.
- Lookup:
  - lookup_hit_o is 1 when any valid entry has an equal address. Combinational over the current state.
  - A same-cycle incoming write is excluded from the check.
- Invariants:
  - usage_o never exceeds NrEntries.
  - empty_o == (usage_o==0).
  - Ordering is strict FIFO.

Optional Feature:
- Macro: SPATZ_VSLDU_WBUF_MERGE_EN.
- When defined:
  - If an accepted write has the same address as the tail (youngest) entry, and that tail is not the head being popped this cycle, the write merges into the tail instead of allocating a new entry.
  - Merge rule: bytes with sld_wbe_i set overwrite the stored data, and tail_be |= sld_wbe_i.
  - Usage and the write pointer are unchanged by a merge.
  - A merge is accepted even when the queue is full.
- When undefined: every accepted write allocates a new entry; there is no merge logic.

Test Plan:
- Basic pass-through:
  - Stimulus: reset, then one write addr=5, data=0xA5.., be=all-ones, with vrf_wvalid_i held 1.
  - Required: sld_wvalid_o=1 in the same cycle; next cycle vrf_we_o=1 with addr=5; usage returns to 0 one cycle later.
- Fill and backpressure:
  - Stimulus: vrf_wvalid_i=0, three consecutive writes at addr 1, 2, 3 with NrEntries=2.
  - Required: first two accepted, third sees sld_wvalid_o=0; usage_o=2, empty_o=0.
- Full with pop:
  - Stimulus: queue full at addr 1, 2; drive vrf_wvalid_i=1 together with a write to addr 3.
  - Required: write accepted; usage stays 2; VRF sees addr 1, 2, 3 in order.
- Lookup:
  - Stimulus: entries at addr 7 and 9 pending; lookup_addr_i=9, then 4.
  - Required: lookup_hit_o=1, then 0; after addr 9 is popped, a lookup of 9 gives 0.
- Reset mid-stream:
  - Stimulus: rst_ni=0 asynchronously while usage=2.
  - Required: vrf_we_o=0 and empty_o=1 immediately, without waiting for a clock edge; no stale write appears after release.
- Merge (macro defined):
  - Stimulus: vrf_wvalid_i=0; write addr=4 with be=0x0F, then addr=4 with be=0xF0.
  - Required: usage=1, and head be=0xFF with the combined data.
  - Same stimulus with the macro undefined: usage=2.
